// File: rtl/riscv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_multicycle_ctrl
//    Multi-cycle control unit for the RV32I core. Steps each instruction
//    through a shared memory and a single ALU. It drives the datapath
//    muxes and enables, the retire pulse and a sticky fault flag.
//
// Ports:
//    clk, rst           clock, synchronous active-high reset
//    opcode, funct3,    instruction fields from the instruction register
//    funct7b5
//    zero               ALU zero flag (branch resolution)
//    mem_ready          memory completes the current access this cycle
//    PCWrite, AdrSrc,   datapath enables and mux selects
//    MemWrite, IRWrite,
//    RegWrite, ResultSrc,
//    ALUSrcA, ALUSrcB,
//    ImmSrc, ALUControl
//    retire             one-cycle pulse on the last cycle of an instruction
//    fault              illegal instruction or memory timeout (absorbing)
//    state_o            current state, for debug
// ---------------------------------------------------------------------------
module riscv_multicycle_ctrl #(
   parameter int unsigned ALU_CTRL_W = 3,
   parameter bit          BNE_EN     = 1'b1,
   parameter int unsigned WAIT_MAX   = 15,
   parameter int unsigned WAIT_CNT_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic                  funct7b5,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  PCWrite,
   output logic                  AdrSrc,
   output logic                  MemWrite,
   output logic                  IRWrite,
   output logic                  RegWrite,
   output logic [1:0]            ResultSrc,
   output logic [1:0]            ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            ImmSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic                  retire,
   output logic                  fault,
   output logic [3:0]            state_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_FAULT    = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   state_t                  state, state_n;
   logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_n;
   logic                    mem_state;
   logic                    timeout;
   aluop_t                  aluop;

   logic                    pcw_c, adr_c, mw_c, irw_c, rw_c, ret_c, flt_c;
   logic [1:0]              rs_c, sa_c, sb_c, imm_c;
   logic [ALU_CTRL_W-1:0]   alu_c;

   // ---------------------------------------------------------------------
   // State and wait-counter registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
      end
   end

   // ---------------------------------------------------------------------
   // Memory wait tracking. The counter restarts whenever the state changes,
   // so every entry into a memory state begins from zero. Timeout fires on
   // the WAIT_MAX-th consecutive not-ready cycle of one access.
   // ---------------------------------------------------------------------
   always_comb begin
      mem_state = (state == S_FETCH) || (state == S_MEMREAD) ||
                  (state == S_MEMWRITE);
      timeout   = mem_state && !mem_ready &&
                  (wait_cnt == WAIT_CNT_W'(WAIT_MAX - 1));
   end

   always_comb begin
      wait_cnt_n = wait_cnt;
      if (state_n != state) begin
         wait_cnt_n = '0;
      end else if (mem_state && !mem_ready) begin
         wait_cnt_n = wait_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Next state and per-state controls
   // ---------------------------------------------------------------------
   always_comb begin
      state_n = state;
      pcw_c   = 1'b0;
      adr_c   = 1'b0;
      mw_c    = 1'b0;
      irw_c   = 1'b0;
      rw_c    = 1'b0;
      ret_c   = 1'b0;
      flt_c   = 1'b0;
      rs_c    = 2'b00;
      sa_c    = 2'b00;
      sb_c    = 2'b00;
      aluop   = ALUOP_ADD;

      case (state)
         S_FETCH: begin
            sa_c  = 2'b00;
            sb_c  = 2'b10;
            rs_c  = 2'b10;
            irw_c = mem_ready;
            pcw_c = mem_ready;
            if (mem_ready) begin
               state_n = S_DECODE;
            end else if (timeout) begin
               state_n = S_FAULT;
            end
         end

         S_DECODE: begin
            sa_c = 2'b01;
            sb_c = 2'b01;
            case (opcode)
               7'b0000011,
               7'b0100011: state_n = S_MEMADR;
               7'b0110011: state_n = S_EXECR;
               7'b0010011: state_n = S_EXECI;
               7'b1100011: state_n = S_BRANCH;
               7'b1101111: state_n = S_JAL;
               default:    state_n = S_FAULT;
            endcase
         end

         S_MEMADR: begin
            sa_c    = 2'b10;
            sb_c    = 2'b01;
            state_n = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         end

         S_MEMREAD: begin
            adr_c = 1'b1;
            if (mem_ready) begin
               state_n = S_MEMWB;
            end else if (timeout) begin
               state_n = S_FAULT;
            end
         end

         S_MEMWB: begin
            rs_c    = 2'b01;
            rw_c    = 1'b1;
            ret_c   = 1'b1;
            state_n = S_FETCH;
         end

         S_MEMWRITE: begin
            adr_c = 1'b1;
            // Drop the strobe on the timeout cycle so a stalled store is
            // not left asserted as the unit enters FAULT.
            mw_c  = !timeout;
            if (mem_ready) begin
               ret_c   = 1'b1;
               state_n = S_FETCH;
            end else if (timeout) begin
               state_n = S_FAULT;
            end
         end

         S_EXECR: begin
            sa_c    = 2'b10;
            sb_c    = 2'b00;
            aluop   = ALUOP_FUNCT;
            state_n = S_ALUWB;
         end

         S_EXECI: begin
            sa_c    = 2'b10;
            sb_c    = 2'b01;
            aluop   = ALUOP_FUNCT;
            state_n = S_ALUWB;
         end

         S_ALUWB: begin
            rs_c    = 2'b00;
            rw_c    = 1'b1;
            ret_c   = 1'b1;
            state_n = S_FETCH;
         end

         S_BRANCH: begin
            sa_c  = 2'b10;
            sb_c  = 2'b00;
            rs_c  = 2'b00;
            aluop = ALUOP_SUB;
            if (funct3 == 3'b000) begin
               pcw_c   = zero;
               ret_c   = 1'b1;
               state_n = S_FETCH;
            end else if ((funct3 == 3'b001) && BNE_EN) begin
               pcw_c   = !zero;
               ret_c   = 1'b1;
               state_n = S_FETCH;
            end else begin
               state_n = S_FAULT;
            end
         end

         S_JAL: begin
            sa_c    = 2'b01;
            sb_c    = 2'b10;
            rs_c    = 2'b00;
            pcw_c   = 1'b1;
            state_n = S_ALUWB;
         end

         S_FAULT: begin
            flt_c = 1'b1;
         end

         default: begin
            state_n = S_FAULT;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // ALU control: fixed add/sub, or funct decode for R/I-type execute
   // ---------------------------------------------------------------------
   always_comb begin
      alu_c = ALU_CTRL_W'(3'b000);
      case (aluop)
         ALUOP_SUB: alu_c = ALU_CTRL_W'(3'b001);
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_c = (opcode[5] && funct7b5) ? ALU_CTRL_W'(3'b001)
                                                        : ALU_CTRL_W'(3'b000);
               3'b010:  alu_c = ALU_CTRL_W'(3'b101);
               3'b110:  alu_c = ALU_CTRL_W'(3'b011);
               3'b111:  alu_c = ALU_CTRL_W'(3'b010);
               default: alu_c = ALU_CTRL_W'(3'b000);
            endcase
         end
         default: alu_c = ALU_CTRL_W'(3'b000);
      endcase
   end

   // Immediate format follows the opcode alone, independent of state.
   always_comb begin
      case (opcode)
         7'b0100011: imm_c = 2'b01;
         7'b1100011: imm_c = 2'b10;
         7'b1101111: imm_c = 2'b11;
         default:    imm_c = 2'b00;
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs are forced low while reset is held, so an access interrupted
   // by reset never sees a further strobe.
   // ---------------------------------------------------------------------
   always_comb begin
      PCWrite    = pcw_c & ~rst;
      AdrSrc     = adr_c & ~rst;
      MemWrite   = mw_c  & ~rst;
      IRWrite    = irw_c & ~rst;
      RegWrite   = rw_c  & ~rst;
      retire     = ret_c & ~rst;
      fault      = flt_c & ~rst;
      ResultSrc  = rst ? '0 : rs_c;
      ALUSrcA    = rst ? '0 : sa_c;
      ALUSrcB    = rst ? '0 : sb_c;
      ImmSrc     = rst ? '0 : imm_c;
      ALUControl = rst ? '0 : alu_c;
      state_o    = rst ? '0 : state;
   end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_multicycle_ctrl
//    Builds, per instruction, the expected cycle-by-cycle output trace from
//    the instruction-level sequencing rules, then drives the stimulus and
//    compares every cycle. A second instance with bne disabled is checked
//    on the bne scenario.
// ---------------------------------------------------------------------------
module tb_riscv_multicycle_ctrl;

   localparam int WAIT_MAX = 15;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                          S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                          S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                          S_BRANCH = 4'd9, S_JAL = 4'd10, S_FAULT = 4'd11;

   localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                          OP_R = 7'b0110011, OP_I = 7'b0010011,
                          OP_B = 7'b1100011, OP_JAL = 7'b1101111;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, adr, mw, irw, rw;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu;
      logic       ret, flt;
   } obs_t;

   typedef struct {
      logic       r, m;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7, z;
      obs_t       e;
   } cyc_t;

   logic       clk, rst, funct7b5, zero, mem_ready;
   logic [6:0] opcode;
   logic [2:0] funct3;

   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, fault;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state_o;

   logic       a_PCWrite, a_AdrSrc, a_MemWrite, a_IRWrite, a_RegWrite, a_retire, a_fault;
   logic [1:0] a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ImmSrc;
   logic [2:0] a_ALUControl;
   logic [3:0] a_state_o;

   cyc_t       q[$];
   cyc_t       qa[$];
   logic [6:0] i_op;
   logic [2:0] i_f3;
   logic       i_f7, i_z;
   int         n_assert, n_fail;

   riscv_multicycle_ctrl #(
      .ALU_CTRL_W(3), .BNE_EN(1'b1), .WAIT_MAX(WAIT_MAX), .WAIT_CNT_W(4)
   ) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .retire(retire), .fault(fault), .state_o(state_o)
   );

   riscv_multicycle_ctrl #(
      .ALU_CTRL_W(3), .BNE_EN(1'b0), .WAIT_MAX(WAIT_MAX), .WAIT_CNT_W(4)
   ) u_alt (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(a_PCWrite), .AdrSrc(a_AdrSrc),
      .MemWrite(a_MemWrite), .IRWrite(a_IRWrite), .RegWrite(a_RegWrite),
      .ResultSrc(a_ResultSrc), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ImmSrc(a_ImmSrc),
      .ALUControl(a_ALUControl), .retire(a_retire), .fault(a_fault), .state_o(a_state_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference rules ----------------
   function automatic logic [1:0] imm_ref(input logic [6:0] op);
      if (op == OP_SW)  return 2'b01;
      if (op == OP_B)   return 2'b10;
      if (op == OP_JAL) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [2:0] alu_ref(input logic [6:0] op, input logic [2:0] f3,
                                          input logic f7);
      case (f3)
         3'b000:  return (op == OP_R && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic obs_t mk(input logic [3:0] st);
      obs_t o = '0;
      o.st  = st;
      o.imm = imm_ref(i_op);
      o.flt = (st == S_FAULT);
      return o;
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic r, input logic m, input obs_t e);
      cyc_t c;
      c.r = r; c.m = m; c.op = i_op; c.f3 = i_f3; c.f7 = i_f7; c.z = i_z; c.e = e;
      q.push_back(c);
   endtask

   task automatic push_reset();
      push(1'b1, rnd_bit(), '0);
   endtask

   task automatic push_fault(input int n);
      for (int i = 0; i < n; i++) push(1'b0, rnd_bit(), mk(S_FAULT));
   endtask

   // Expected trace for one instruction: wf / wm are the not-ready cycles
   // before the fetch / data access completes (>= WAIT_MAX means timeout).
   task automatic build_instr(input int wf, input int wm, input bit bne_en);
      obs_t       o;
      logic [3:0] st;
      bit         is_st, taken_ok;
      for (int i = 0; i < wf && i < WAIT_MAX; i++) begin
         o = mk(S_FETCH); o.sb = 2'b10; o.rs = 2'b10;
         push(1'b0, 1'b0, o);
      end
      if (wf >= WAIT_MAX) begin push_fault(4); return; end
      o = mk(S_FETCH); o.sb = 2'b10; o.rs = 2'b10; o.pcw = 1'b1; o.irw = 1'b1;
      push(1'b0, 1'b1, o);
      o = mk(S_DECODE); o.sa = 2'b01; o.sb = 2'b01;
      push(1'b0, rnd_bit(), o);
      if (i_op == OP_LW || i_op == OP_SW) begin
         is_st = (i_op == OP_SW);
         o = mk(S_MEMADR); o.sa = 2'b10; o.sb = 2'b01;
         push(1'b0, rnd_bit(), o);
         st = is_st ? S_MEMWRITE : S_MEMREAD;
         for (int i = 0; i < wm && i < WAIT_MAX; i++) begin
            o = mk(st); o.adr = 1'b1; o.mw = is_st && (i != WAIT_MAX - 1);
            push(1'b0, 1'b0, o);
         end
         if (wm >= WAIT_MAX) begin push_fault(4); return; end
         o = mk(st); o.adr = 1'b1; o.mw = is_st; o.ret = is_st;
         push(1'b0, 1'b1, o);
         if (!is_st) begin
            o = mk(S_MEMWB); o.rs = 2'b01; o.rw = 1'b1; o.ret = 1'b1;
            push(1'b0, rnd_bit(), o);
         end
      end else if (i_op == OP_R || i_op == OP_I || i_op == OP_JAL) begin
         if (i_op == OP_JAL) begin
            o = mk(S_JAL); o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1;
         end else begin
            o = mk(i_op == OP_R ? S_EXECR : S_EXECI);
            o.sa = 2'b10; o.sb = (i_op == OP_R) ? 2'b00 : 2'b01;
            o.alu = alu_ref(i_op, i_f3, i_f7);
         end
         push(1'b0, rnd_bit(), o);
         o = mk(S_ALUWB); o.rw = 1'b1; o.ret = 1'b1;
         push(1'b0, rnd_bit(), o);
      end else if (i_op == OP_B) begin
         taken_ok = (i_f3 == 3'd0) || (i_f3 == 3'd1 && bne_en);
         o = mk(S_BRANCH); o.sa = 2'b10; o.alu = 3'b001;
         if (taken_ok) begin
            o.pcw = (i_f3 == 3'd0) ? i_z : !i_z;
            o.ret = 1'b1;
         end
         push(1'b0, rnd_bit(), o);
         if (!taken_ok) push_fault(4);
      end else begin
         push_fault(4);
      end
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z);
      i_op = op; i_f3 = f3; i_f7 = f7; i_z = z;
   endtask

   task automatic step(input cyc_t c, output obs_t a, output obs_t a2);
      @(negedge clk);
      rst = c.r; mem_ready = c.m; opcode = c.op; funct3 = c.f3;
      funct7b5 = c.f7; zero = c.z;
      #1;
      a  = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ImmSrc, ALUControl, retire, fault};
      a2 = {a_state_o, a_PCWrite, a_AdrSrc, a_MemWrite, a_IRWrite, a_RegWrite,
            a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ImmSrc, a_ALUControl, a_retire, a_fault};
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      cyc_t c; obs_t a, a2, o; int k = 0;
      set_instr(OP_SW, 3'd5, 1'b1, 1'b1);
      push_reset(); push_reset();
      o = mk(S_FETCH); o.sb = 2'b10; o.rs = 2'b10;
      push(1'b0, 1'b0, o);
      while (q.size() != 0) begin
         c = q.pop_front(); step(c, a, a2); n_assert++;
         if (a !== c.e) begin
            n_fail++; $display("FAIL reset cyc%0d: got %h expected %h", k, a, c.e);
         end
         k++;
      end
   endtask

   task automatic test_load();
      cyc_t c; obs_t a, a2; int k = 0; int rets = 0;
      set_instr(OP_LW, 3'd2, 1'b0, 1'b0);
      push_reset();
      build_instr(0, 0, 1'b1);
      while (q.size() != 0) begin
         c = q.pop_front(); step(c, a, a2); n_assert++;
         if (a !== c.e) begin
            n_fail++; $display("FAIL load cyc%0d: got %h expected %h", k, a, c.e);
         end
         rets += int'(a.ret);
         k++;
      end
      n_assert++;
      if (rets !== 1) begin
         n_fail++; $display("FAIL load_retire_count: got %0d expected 1", rets);
      end
   endtask

   task automatic test_store();
      cyc_t c; obs_t a, a2; int k = 0; int mws = 0;
      set_instr(OP_SW, 3'd2, 1'b0, 1'b0);
      push_reset();
      build_instr(1, 3, 1'b1);
      while (q.size() != 0) begin
         c = q.pop_front(); step(c, a, a2); n_assert++;
         if (a !== c.e) begin
            n_fail++; $display("FAIL store cyc%0d: got %h expected %h", k, a, c.e);
         end
         mws += int'(a.mw);
         k++;
      end
      n_assert++;
      if (mws !== 4) begin
         n_fail++; $display("FAIL store_memwrite_cycles: got %0d expected 4", mws);
      end
   endtask

   task automatic test_branch();
      cyc_t c; obs_t a, a2; int k = 0;
      push_reset();
      set_instr(OP_B, 3'd0, 1'b0, 1'b1); build_instr(0, 0, 1'b1);
      set_instr(OP_B, 3'd0, 1'b0, 1'b0); build_instr(2, 0, 1'b1);
      set_instr(OP_B, 3'd1, 1'b0, 1'b0); build_instr(0, 0, 1'b1);
      set_instr(OP_B, 3'd1, 1'b1, 1'b1); build_instr(0, 0, 1'b1);
      set_instr(OP_JAL, 3'd3, 1'b0, 1'b0); build_instr(0, 0, 1'b1);
      while (q.size() != 0) begin
         c = q.pop_front(); step(c, a, a2); n_assert++;
         if (a !== c.e) begin
            n_fail++; $display("FAIL branch cyc%0d: got %h expected %h", k, a, c.e);
         end
         k++;
      end
   endtask

   task automatic test_bne_disabled();
      cyc_t c, ca; obs_t a, a2; int k = 0;
      set_instr(OP_B, 3'd1, 1'b0, 1'b0);
      push_reset(); build_instr(0, 0, 1'b0);
      qa = q; q.delete();
      push_reset(); build_instr(0, 0, 1'b1); build_instr(0, 0, 1'b1);
      while (q.size() != 0) begin
         c = q.pop_front(); step(c, a, a2); n_assert++;
         if (a !== c.e) begin
            n_fail++; $display("FAIL bne_en1 cyc%0d: got %h expected %h", k, a, c.e);
         end
         if (qa.size() != 0) begin
            ca = qa.pop_front(); n_assert++;
            if (a2 !== ca.e) begin
               n_fail++; $display("FAIL bne_en0 cyc%0d: got %h expected %h", k, a2, ca.e);
            end
         end
         k++;
      end
   endtask

   task automatic test_alu();
      cyc_t c; obs_t a, a2; int k = 0;
      logic [2:0] f3s [5];
      f3s[0] = 3'd0; f3s[1] = 3'd2; f3s[2] = 3'd6; f3s[3] = 3'd7; f3s[4] = 3'd1;
      push_reset();
      set_instr(OP_R, 3'd0, 1'b1, 1'b0); build_instr(0, 0, 1'b1);
      set_instr(OP_I, 3'd0, 1'b1, 1'b0); build_instr(0, 0, 1'b1);
      foreach (f3s[i]) begin
         set_instr(OP_R, f3s[i], 1'b0, 1'b1); build_instr(0, 0, 1'b1);
         set_instr(OP_I, f3s[i], 1'b1, 1'b0); build_instr(0, 0, 1'b1);
      end
      while (q.size() != 0) begin
         c = q.pop_front(); step(c, a, a2); n_assert++;
         if (a !== c.e) begin
            n_fail++; $display("FAIL alu cyc%0d: got %h expected %h", k, a, c.e);
         end
         k++;
      end
   endtask

   task automatic test_timeout();
      cyc_t c; obs_t a, a2; int k = 0;
      set_instr(OP_LW, 3'd2, 1'b0, 1'b0);
      push_reset(); build_instr(WAIT_MAX, 0, 1'b1);
      push_reset();
      build_instr(WAIT_MAX - 1, 0, 1'b1);
      set_instr(OP_SW, 3'd2, 1'b0, 1'b0); build_instr(0, WAIT_MAX, 1'b1);
      push_reset();
      set_instr(7'b1111111, 3'd0, 1'b0, 1'b0); build_instr(0, 0, 1'b1);
      push_reset();
      set_instr(OP_LW, 3'd2, 1'b0, 1'b0); build_instr(0, WAIT_MAX, 1'b1);
      while (q.size() != 0) begin
         c = q.pop_front(); step(c, a, a2); n_assert++;
         if (a !== c.e) begin
            n_fail++; $display("FAIL timeout_illegal cyc%0d: got %h expected %h", k, a, c.e);
         end
         k++;
      end
   endtask

   task automatic test_reset_mid_write();
      cyc_t c; obs_t a, a2; int k = 0;
      set_instr(OP_SW, 3'd2, 1'b0, 1'b0);
      push_reset(); build_instr(0, 3, 1'b1);
      void'(q.pop_back()); void'(q.pop_back());
      push(1'b1, 1'b0, '0);
      set_instr(OP_R, 3'd7, 1'b0, 1'b0); build_instr(0, 0, 1'b1);
      while (q.size() != 0) begin
         c = q.pop_front(); step(c, a, a2); n_assert++;
         if (a !== c.e) begin
            n_fail++; $display("FAIL reset_mid_write cyc%0d: got %h expected %h", k, a, c.e);
         end
         k++;
      end
   endtask

   task automatic test_random();
      cyc_t c; obs_t a, a2; int k = 0; int wf, wm;
      logic [6:0] ops [10];
      ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_I; ops[4] = OP_B;
      ops[5] = OP_JAL; ops[6] = 7'h37; ops[7] = 7'h67; ops[8] = OP_B; ops[9] = OP_R;
      push_reset();
      for (int n = 0; n < 150; n++) begin
         set_instr(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), rnd_bit(), rnd_bit());
         if (i_op == OP_B && rnd_bit()) i_f3 = 3'($urandom_range(0, 1));
         wf = ($urandom_range(0, 29) == 0) ? WAIT_MAX : int'($urandom_range(0, 3));
         wm = ($urandom_range(0, 19) == 0) ? WAIT_MAX : int'($urandom_range(0, 4));
         build_instr(wf, wm, 1'b1);
         if (q[q.size() - 1].e.flt) push_reset();
         while (q.size() != 0) begin
            c = q.pop_front(); step(c, a, a2); n_assert++;
            if (a !== c.e) begin
               n_fail++;
               $display("FAIL random op=%b f3=%0d cyc%0d: got %h expected %h",
                        c.op, c.f3, k, a, c.e);
            end
            k++;
         end
      end
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      rst = 1'b1; mem_ready = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
      i_op = '0; i_f3 = '0; i_f7 = 1'b0; i_z = 1'b0;
      test_reset();
      test_load();
      test_store();
      test_branch();
      test_bne_disabled();
      test_alu();
      test_timeout();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Parametrised multi-cycle control unit for the next-generation RV32I core. It replaces the single-cycle combinational decoder with a state machine that sequences each instruction through one shared memory and one ALU. It also adds branch, jump and memory-ready handshakes, a memory-wait timeout and a retire pulse. It drives the multi-cycle datapath muxes and enables, and receives the opcode and funct fields from the instruction register.

Parameters:
ALU_CTRL_W, 3, width of ALUControl
BNE_EN, 1, 1 = also decode bne (funct3=001, taken when !zero); 0 = funct3=001 branches are illegal
WAIT_MAX, 15, maximum consecutive cycles with mem_ready low in a memory state before fault
WAIT_CNT_W, 4, width of the wait counter (must hold WAIT_MAX)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
opcode  in  7  instruction bits [6:0]
funct3  in  3  instruction bits [14:12]
funct7b5  in  1  instruction bit 30
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction/OldPC register enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; decoded from opcode only, every state
ALUControl  out  ALU_CTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
retire  out  1  one-cycle pulse on the last cycle of each instruction
fault  out  1  sticky: illegal instruction or memory timeout
state_o  out  4  current state encoding, for debug

Behaviour:
- Registered state only; all other outputs are combinational from state and inputs. While rst=1 every output is 0. The first cycle after reset is FETCH.
- Unlisted outputs are 0 in each state. Default ALUControl is add. ALUOp=10 selects the funct decode below.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> FAULT
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next is MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready. retire=1 on the mem_ready cycle, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=sub, ResultSrc=00. PCWrite=zero for funct3=000, and !zero for funct3=001 when BNE_EN=1. Any other funct3 goes to FAULT with PCWrite=0. Otherwise retire=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1, then ALUWB (writes PC+4 to rd).
- ALUOp=10 decode, by funct3:
  - 000: sub if opcode[5] & funct7b5, else add
  - 010: slt
  - 110: or
  - 111: and
  - others: add
- Wait counter: cleared on entry to FETCH, MEMREAD or MEMWRITE. Increments each cycle mem_ready=0 in those states. When the count reaches WAIT_MAX with mem_ready still 0, the next state is FAULT and MemWrite deasserts in that cycle.
- FAULT: fault=1 and all enables are 0. The state is absorbing; only rst leaves it.
- rst asserted in any state, including mid-access: state returns to FETCH, the counter clears, and fault clears on the next edge. No partial write is completed after reset.
- mem_ready is ignored in non-memory states.

Test Plan:
- Reset, then lw (opcode 0000011) with mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. 5 cycles, RegWrite=1 and ResultSrc=01 only in cycle 5, retire pulses once.
- sw (0100011) with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, retire on the 4th, then FETCH.
- beq with zero=1, then zero=0 -> PCWrite=1 in BRANCH for the first case, 0 for the second. bne (funct3=001, BNE_EN=1) with zero=0 -> PCWrite=1. With BNE_EN=0 -> FAULT.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECR. addi with funct7b5=1 -> ALUControl=000.
- mem_ready held 0 in FETCH for WAIT_MAX=15 cycles -> FAULT, fault=1 sticky, IRWrite stays 0. Opcode 1111111 -> FAULT after DECODE.
- rst pulsed during MEMWRITE with mem_ready=0 -> all outputs 0 during rst, then FETCH, fault=0.
